// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: runs an N-byte chip-select-framed burst through the spictrl byte engine,
// fed from a TX FIFO and captured into an RX FIFO. Optional handshake watchdog: SPI_SEQ_TIMEOUT_EN.
module spi_xfer_seq #(
    parameter int FIFO_AW  = 2,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int TO_CYC   = 128
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_wdata_i,
    input  logic       tx_wr_i,
    output logic       tx_full_o,
    output logic [7:0] rx_rdata_o,
    input  logic       rx_rd_i,
    output logic       rx_empty_o,
    input  logic [7:0] cmd_len_i,
    input  logic       cmd_rx_en_i,
    input  logic       cmd_go_i,
    output logic       seq_busy_o,
    output logic       done_o,
    output logic       spi_cs_n_o,
    output logic [7:0] eng_txdata_o,
    output logic       eng_txstart_o,
    input  logic [7:0] eng_rxdata_i,
    input  logic       eng_busy_i,
    output logic       timeout_err_o
);
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT_HI, WAIT_LO, CAPTURE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    len_q, len_d;
    logic          rx_en_q, rx_en_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    txdata_q, txdata_d;
    logic          txstart_q, txstart_d;
    logic          done_q, done_d;

    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic             tx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign tx_empty   = (tx_wp_q == tx_rp_q);
    assign tx_full_o  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                        (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign rx_empty_o = (rx_wp_q == rx_rp_q);
    assign rx_full    = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                        (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign tx_push    = tx_wr_i && !tx_full_o;
    assign rx_pop     = rx_rd_i && !rx_empty_o;
    assign rx_rdata_o = rx_mem[rx_rp_q[FIFO_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= tx_wdata_i;
        if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= eng_rxdata_i;
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_q, to_d;
    logic          terr_q, terr_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rx_en_d   = rx_en_q;
        cs_n_d    = cs_n_q;
        txdata_d  = txdata_q;
        txstart_d = 1'b0;
        done_d    = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            IDLE: if (cmd_go_i && cmd_len_i != 8'd0) begin
                state_d = SETUP;
                len_d   = cmd_len_i;
                rx_en_d = cmd_rx_en_i;
                cs_n_d  = 1'b0;
                cnt_d   = '0;
            end
            SETUP: if (cnt_q == CW'(CS_SETUP - 1)) state_d = LOAD;
                   else cnt_d = cnt_q + CW'(1);
            LOAD: begin
                tx_pop    = !tx_empty;
                txdata_d  = tx_empty ? 8'hFF : tx_mem[tx_rp_q[FIFO_AW-1:0]];
                txstart_d = 1'b1;
                state_d   = WAIT_HI;
            end
            WAIT_HI: if (eng_busy_i) state_d = WAIT_LO;
            WAIT_LO: if (!eng_busy_i) state_d = CAPTURE;
            // A full RX FIFO holds the burst here; the engine stays idle until the CPU pops.
            CAPTURE: if (!(rx_en_q && rx_full)) begin
                rx_push = rx_en_q;
                len_d   = len_q - 8'd1;
                cnt_d   = '0;
                state_d = (len_q == 8'd1) ? HOLD : LOAD;
            end
            HOLD: if (cnt_q == CW'(CS_HOLD - 1)) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_SEQ_TIMEOUT_EN
        to_d   = '0;
        terr_d = terr_q;
        if (state_q == IDLE && state_d == SETUP) terr_d = 1'b0;
        if ((state_q == WAIT_HI || state_q == WAIT_LO) && state_d == state_q) begin
            if (to_q == TW'(TO_CYC - 1)) begin
                terr_d  = 1'b1;
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= 8'd0;
            rx_en_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            txdata_q  <= 8'd0;
            txstart_q <= 1'b0;
            done_q    <= 1'b0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rx_en_q   <= rx_en_d;
            cs_n_q    <= cs_n_d;
            txdata_q  <= txdata_d;
            txstart_q <= txstart_d;
            done_q    <= done_d;
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign seq_busy_o    = (state_q != IDLE);
    assign done_o        = done_q;
    assign spi_cs_n_o    = cs_n_q;
    assign eng_txdata_o  = txdata_q;
    assign eng_txstart_o = txstart_q;

endmodule
